pattern_gen_sequencer: RTL

- Autonomous controller for the custom pattern generator.
- Loads an incrementing pattern into the generator's pattern RAM, programs the payload-length and pattern-position/length CSRs, then issues start.
- Counts accepted source beats and writes stop after a programmed beat count.
- Sits between the host control registers and the generator's CSR and pattern slave ports; replaces manual CSR/pattern sequencing.

---
 rtl/pattern_gen_sequencer_if.sv | 49 ++++
 rtl/pattern_gen_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_sequencer_if.sv
// Host-control, generator CSR/pattern-port and source-monitor signals of the sequencer.
// master = sequencer side, slave = host/generator side.
interface pattern_gen_sequencer_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_WIDTH    = 6,
  parameter int BEAT_COUNT_WIDTH = 32
);
  logic                        go;
  logic                        abort;
  logic [31:0]                 cfg_payload_length;
  logic [15:0]                 cfg_pattern_position;
  logic [15:0]                 cfg_pattern_length;
  logic [DATA_WIDTH-1:0]       cfg_seed;
  logic [BEAT_COUNT_WIDTH-1:0] cfg_beat_target;

  logic [1:0]                  csr_address;
  logic [31:0]                 csr_writedata;
  logic                        csr_write;
  logic [3:0]                  csr_byteenable;

  logic [ADDRESS_WIDTH-1:0]    pattern_address;
  logic [DATA_WIDTH-1:0]       pattern_writedata;
  logic                        pattern_write;
  logic [DATA_WIDTH/8-1:0]     pattern_byteenable;

  logic                        src_valid;
  logic                        src_ready;

  logic                        busy;
  logic                        done;
  logic                        error;
  logic [BEAT_COUNT_WIDTH-1:0] beats_seen;

  modport master (
    input  go, abort, cfg_payload_length, cfg_pattern_position, cfg_pattern_length,
           cfg_seed, cfg_beat_target, src_valid, src_ready,
    output csr_address, csr_writedata, csr_write, csr_byteenable,
           pattern_address, pattern_writedata, pattern_write, pattern_byteenable,
           busy, done, error, beats_seen
  );

  modport slave (
    output go, abort, cfg_payload_length, cfg_pattern_position, cfg_pattern_length,
           cfg_seed, cfg_beat_target, src_valid, src_ready,
    input  csr_address, csr_writedata, csr_write, csr_byteenable,
           pattern_address, pattern_writedata, pattern_write, pattern_byteenable,
           busy, done, error, beats_seen
  );
endinterface

// File: rtl/pattern_gen_sequencer.sv
// Loads an incrementing pattern, programs the generator CSRs, starts it, stops after N beats.
// All outputs registered; one write strobe per cycle, generator never stalls the writes.
module pattern_gen_sequencer #(
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_PATTERN_LENGTH = 64,
  parameter int ADDRESS_WIDTH      = 6,
  parameter int BEAT_COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pattern_gen_sequencer_if.master bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CFG_PAYLOAD, S_CFG_PATTERN, S_START, S_RUN, S_STOP, S_DONE
  } state_t;

  state_t                      state_q;
  logic [31:0]                 payload_q;
  logic [15:0]                 position_q;
  logic [15:0]                 length_q;
  logic [BEAT_COUNT_WIDTH-1:0] target_q;

  logic [1:0]                  csr_address_q;
  logic [31:0]                 csr_writedata_q;
  logic                        csr_write_q;
  logic [3:0]                  csr_byteenable_q;
  logic [ADDRESS_WIDTH-1:0]    pattern_address_q;
  logic [DATA_WIDTH-1:0]       pattern_writedata_q;
  logic                        pattern_write_q;
  logic [BE_W-1:0]             pattern_byteenable_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        error_q;
  logic [BEAT_COUNT_WIDTH-1:0] beats_q;

  logic                        fire;
  logic                        len_bad;
  logic                        last_word;
  logic                        target_hit;
  logic [BEAT_COUNT_WIDTH-1:0] beats_d;

  assign fire       = bus.src_valid & bus.src_ready;
  assign len_bad    = (bus.cfg_pattern_length == 16'd0) ||
                      (int'(bus.cfg_pattern_length) > MAX_PATTERN_LENGTH);
  assign last_word  = (16'(pattern_address_q) == (length_q - 16'd1));
  // Saturating count; the target compare uses the post-increment value.
  assign beats_d    = (beats_q == '1) ? beats_q : beats_q + 1'b1;
  assign target_hit = fire && (target_q != '0) && (beats_d == target_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= S_IDLE;
      payload_q            <= '0;
      position_q           <= '0;
      length_q             <= '0;
      target_q             <= '0;
      csr_address_q        <= '0;
      csr_writedata_q      <= '0;
      csr_write_q          <= 1'b0;
      csr_byteenable_q     <= '0;
      pattern_address_q    <= '0;
      pattern_writedata_q  <= '0;
      pattern_write_q      <= 1'b0;
      pattern_byteenable_q <= '0;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
      error_q              <= 1'b0;
      beats_q              <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            payload_q  <= bus.cfg_payload_length;
            position_q <= bus.cfg_pattern_position;
            length_q   <= bus.cfg_pattern_length;
            target_q   <= bus.cfg_beat_target;
            beats_q    <= '0;
            error_q    <= len_bad;
            busy_q     <= 1'b1;
            if (len_bad) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pattern_write_q      <= 1'b1;
              pattern_address_q    <= '0;
              pattern_writedata_q  <= bus.cfg_seed;
              pattern_byteenable_q <= {BE_W{1'b1}};
              state_q              <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            pattern_write_q <= 1'b0;
            done_q          <= 1'b1;
            state_q         <= S_DONE;
          end else if (last_word) begin
            pattern_write_q  <= 1'b0;
            csr_write_q      <= 1'b1;
            csr_address_q    <= 2'd0;
            csr_writedata_q  <= payload_q;
            csr_byteenable_q <= 4'hF;
            state_q          <= S_CFG_PAYLOAD;
          end else begin
            pattern_address_q   <= pattern_address_q + 1'b1;
            pattern_writedata_q <= pattern_writedata_q + 1'b1;
          end
        end
        S_CFG_PAYLOAD: begin
          if (bus.abort) begin
            csr_write_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            csr_address_q    <= 2'd1;
            csr_writedata_q  <= {position_q, length_q};
            csr_byteenable_q <= 4'hF;
            state_q          <= S_CFG_PATTERN;
          end
        end
        S_CFG_PATTERN: begin
          if (bus.abort) begin
            csr_write_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            csr_address_q    <= 2'd2;
            csr_writedata_q  <= 32'h0100_0000;
            csr_byteenable_q <= 4'h8;
            state_q          <= S_START;
          end
        end
        S_START: begin
          csr_write_q <= 1'b0;
          if (bus.abort) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (fire) beats_q <= beats_d;
          if (bus.abort || target_hit) begin
            csr_write_q      <= 1'b1;
            csr_address_q    <= 2'd2;
            csr_writedata_q  <= 32'h0000_0000;
            csr_byteenable_q <= 4'h8;
            state_q          <= S_STOP;
          end
        end
        S_STOP: begin
          csr_write_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.csr_address        = csr_address_q;
  assign bus.csr_writedata      = csr_writedata_q;
  assign bus.csr_write          = csr_write_q;
  assign bus.csr_byteenable     = csr_byteenable_q;
  assign bus.pattern_address    = pattern_address_q;
  assign bus.pattern_writedata  = pattern_writedata_q;
  assign bus.pattern_write      = pattern_write_q;
  assign bus.pattern_byteenable = pattern_byteenable_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.error              = error_q;
  assign bus.beats_seen         = beats_q;

endmodule
